ita_requant_output_buffer: RTL
==============================

ITA_REQUANT_OUTPUT_BUFFER -- requirements
Module: ita_requant_output_buffer

Interface
REQ-001 SHALL have parameter N, default 16, lanes per vector (matches requantizer lane count).
REQ-002 SHALL have parameter WI, default 8, bits per lane (signed requantized output).
REQ-003 SHALL have parameter DEPTH, default 4, vector entries; power of two, >=2.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port flush_i  input  1  synchronous clear of buffer contents.
REQ-007 SHALL have port valid_i  input  1  requantized vector present on data_i this cycle.
REQ-008 SHALL have port data_i  input  N*WI  requantized vector, lane i at bits [i*WI +: WI].
REQ-009 SHALL have port ready_o  output  1  high when at least one entry is free (advisory; upstream has no stall).
REQ-010 SHALL have port valid_o  output  1  head entry available on data_o.
REQ-011 SHALL have port data_o  output  N*WI  head entry, same lane packing as data_i.
REQ-012 SHALL have port ready_i  input  1  downstream accepts head when valid_o & ready_i.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-014 SHALL have port overflow_o  output  1  sticky: a vector was dropped.
REQ-015 SHALL have port sat_cnt_o  output  32  saturated-lane count (see Configuration).

Function
REQ-016 SHALL implement a circular FIFO of DEPTH vectors with wr_ptr, rd_ptr wrapping modulo DEPTH and a separate occupancy counter.
REQ-017 SHALL track state EMPTY (count 0), PARTIAL (1..DEPTH-1), FULL (count DEPTH); valid_o = state != EMPTY, ready_o = state != FULL.
REQ-018 SHALL push when valid_i and (not FULL, or FULL with pop in same cycle); pop when valid_o & ready_i.
REQ-019 SHALL hold count on simultaneous push and pop in PARTIAL or FULL; in EMPTY a push with ready_i high SHALL NOT bypass (valid_o rises next cycle).
REQ-020 SHALL present data_o directly from the storage entry at rd_ptr; latency valid_i to valid_o is exactly 1 cycle when EMPTY.
REQ-021 SHALL keep data_o stable while valid_o & !ready_i.
REQ-022 SHALL, on valid_i while FULL without a pop, drop the vector, leave contents unchanged and set overflow_o from the next cycle until reset.
REQ-023 SHALL, on flush_i, zero pointers and count next cycle, ignore push/pop that cycle, and leave overflow_o and sat_cnt_o unchanged.
REQ-024 SHALL keep data_o stable-undefined-free: when EMPTY it shows the last-written entry at rd_ptr (not checked by bench).

Reset
REQ-025 SHALL, while rst_i high, force pointers, count, overflow_o, sat_cnt_o to 0; valid_o 0, ready_o 1, count_o 0, data_o 0 (storage cleared).
REQ-026 SHALL, if reset asserts mid-operation, discard all entries immediately; first push after release behaves as from EMPTY.

Configuration
REQ-027 SHALL, with macro ITA_OUTBUF_SAT_STATS_EN defined, increment sat_cnt_o on each accepted push by the number of lanes equal to +(2^(WI-1)-1) or -(2^(WI-1)), saturating at 2^32-1.
REQ-028 SHALL, without ITA_OUTBUF_SAT_STATS_EN, tie sat_cnt_o to 0 and instantiate no counting logic.
REQ-029 SHALL NOT count dropped (overflow) vectors in sat_cnt_o.

Verification
REQ-030 Reset then single push data_i lane0=0x05, ready_i=0 -> next cycle valid_o=1, count_o=1, data_o lane0=0x05.
REQ-031 DEPTH=4, ready_i=0, 5 consecutive pushes 1..5 -> count_o=4, ready_o=0, overflow_o=1 after 5th; drain yields 1,2,3,4.
REQ-032 FULL, push 9 with ready_i=1 same cycle -> count_o stays 4, head pops, 9 read out last; overflow_o stays 0.
REQ-033 Push 10 vectors with ready_i toggling every cycle -> output order 1..10, no loss, pointer wrap exercised.
REQ-034 3 entries held, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, pushed vector discarded.
REQ-035 ITA_OUTBUF_SAT_STATS_EN, push vector with lanes 0x7F,0x80,0x7F,rest 0x00 -> sat_cnt_o=3; without macro sat_cnt_o=0.

Source files
------------

// File: rtl/ita_requant_output_buffer.sv
// ita_requant_output_buffer: circular FIFO buffering requantized N-lane vectors for downstream.
// Ports: clk_i/rst_i (async active-high), flush_i sync clear; valid_i/data_i upstream push
// (no stall, ready_o advisory); valid_o/data_o/ready_i downstream pop; count_o occupancy;
// overflow_o sticky drop flag; sat_cnt_o saturated-lane count.
// Define ITA_OUTBUF_SAT_STATS_EN to enable saturated-lane counting (else sat_cnt_o is 0).
module ita_requant_output_buffer #(
  parameter int N     = 16,
  parameter int WI    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [N*WI-1:0]            data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [N*WI-1:0]            data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [31:0]                sat_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
  state_t state_q, state_d;
  logic [N*WI-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop, ovf_q;
  // a push into FULL is only allowed when the head leaves in the same cycle
  always_comb begin
    pop     = (state_q != EMPTY) & ready_i & !flush_i;
    push    = valid_i & !flush_i & ((state_q != FULL) | pop);
    cnt_d   = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    state_d = (cnt_d == '0) ? EMPTY : (cnt_d == CW'(DEPTH)) ? FULL : PARTIAL;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= flush_i ? '0 : wr_q + PW'(push);
      rd_q    <= flush_i ? '0 : rd_q + PW'(pop);
      if (push) mem_q[wr_q] <= data_i;
      if (valid_i & (state_q == FULL) & !pop & !flush_i) ovf_q <= 1'b1;
    end
  end
  assign ready_o    = state_q != FULL;
  assign valid_o    = state_q != EMPTY;
  assign data_o     = mem_q[rd_q];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;
`ifdef ITA_OUTBUF_SAT_STATS_EN
  localparam logic [WI-1:0] SMAX = {1'b0, {(WI-1){1'b1}}};
  localparam logic [WI-1:0] SMIN = {1'b1, {(WI-1){1'b0}}};
  logic [31:0] sat_q, nsat;
  logic [32:0] sat_sum;
  always_comb begin
    nsat = '0;
    for (int i = 0; i < N; i++)
      nsat = nsat + 32'((data_i[i*WI +: WI] == SMAX) | (data_i[i*WI +: WI] == SMIN));
    sat_sum = {1'b0, sat_q} + {1'b0, nsat};
  end
  // only accepted pushes count, so dropped and flushed vectors are excluded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_q <= '0;
    else if (push) sat_q <= sat_sum[32] ? '1 : sat_sum[31:0];
  end
  assign sat_cnt_o = sat_q;
`else
  assign sat_cnt_o = '0;
`endif
endmodule
